// File: rtl/ch4_noise.sv
// ch4_noise: APU channel-4 noise generator (divider, prescaler, 15/7-bit LFSR, envelope).
// Optional macro CH4_NOISE_ENV_EN builds the volume envelope; without it volume is fixed at restart.
`default_nettype none

module ch4_noise (
  input  logic        clk,
  input  logic        apu_reset,
  input  logic        ce_1m,
  input  logic        env_tick,
  input  logic [7:0]  ff21_q,
  input  logic [7:0]  ff22_q,
  input  logic        ch4_restart,
  input  logic        ch4_len_expire,
  output logic        ch4_active,
  output logic [3:0]  ch4_out,
  output logic [14:0] lfsr_q
);

  logic [14:0] lfsr_state_q;
  logic [14:0] lfsr_d;
  logic [7:0]  div_q;
  logic [13:0] presc_q;
  logic [3:0]  vol_q;
  logic        active_q;
  logic        active_d;

  logic        dac_on;
  logic        div_pulse;
  logic        shift_strobe;
  logic        fb;
  logic [7:0]  div_reload;
  logic [15:0] presc_cur;
  logic [15:0] presc_nxt;

`ifdef CH4_NOISE_ENV_EN
  logic [2:0]  env_cnt_q;
  logic [2:0]  env_per_q;
`else
  logic        unused_env;
  assign unused_env = ^{env_tick, ff21_q[2:0]};
`endif

  always_comb begin
    dac_on     = |ff21_q[7:3];
    div_reload = (ff22_q[2:0] == 3'd0) ? 8'd1 : {4'd0, ff22_q[2:0], 1'b0};
    div_pulse  = ce_1m && (div_q <= 8'd1);
    // Zero-extended to 16 bits so shift codes 14/15 select a constant 0 and never strobe.
    presc_cur    = {2'b00, presc_q};
    presc_nxt    = {2'b00, presc_q + 14'd1};
    shift_strobe = div_pulse && !presc_cur[ff22_q[7:4]] && presc_nxt[ff22_q[7:4]];
    fb     = lfsr_state_q[0] ^ lfsr_state_q[1];
    lfsr_d = {fb, lfsr_state_q[14:1]};
    if (ff22_q[3]) begin
      lfsr_d[6] = fb;
    end
    active_d = active_q && !ch4_len_expire && dac_on;
  end

  always_ff @(posedge clk or posedge apu_reset) begin
    if (apu_reset) begin
      lfsr_state_q <= 15'd0;
      div_q        <= 8'd0;
      presc_q      <= 14'd0;
      vol_q        <= 4'd0;
      active_q     <= 1'b0;
`ifdef CH4_NOISE_ENV_EN
      env_cnt_q    <= 3'd0;
      env_per_q    <= 3'd0;
`endif
    end else if (ch4_restart) begin
      lfsr_state_q <= 15'h7FFF;
      div_q        <= div_reload;
      presc_q      <= 14'd0;
      vol_q        <= ff21_q[7:4];
      active_q     <= dac_on;
`ifdef CH4_NOISE_ENV_EN
      env_cnt_q    <= ff21_q[2:0];
      env_per_q    <= ff21_q[2:0];
`endif
    end else begin
      active_q <= active_d;
      if (ce_1m) begin
        div_q <= div_pulse ? div_reload : div_q - 8'd1;
      end
      if (div_pulse) begin
        presc_q <= presc_q + 14'd1;
      end
      if (shift_strobe && active_q) begin
        lfsr_state_q <= lfsr_d;
      end
`ifdef CH4_NOISE_ENV_EN
      // Period and direction are re-sampled from NR42 at each reload.
      if (env_tick && (env_per_q != 3'd0)) begin
        if (env_cnt_q <= 3'd1) begin
          env_cnt_q <= ff21_q[2:0];
          env_per_q <= ff21_q[2:0];
          if (ff21_q[3] && (vol_q != 4'hF)) begin
            vol_q <= vol_q + 4'd1;
          end else if (!ff21_q[3] && (vol_q != 4'h0)) begin
            vol_q <= vol_q - 4'd1;
          end
        end else begin
          env_cnt_q <= env_cnt_q - 3'd1;
        end
      end
`endif
    end
  end

  assign ch4_active = active_q;
  assign lfsr_q     = lfsr_state_q;
  assign ch4_out    = (active_q && !lfsr_state_q[0]) ? vol_q : 4'd0;

endmodule

`default_nettype wire

// File: tb/tb_ch4_noise.sv
// tb_ch4_noise: scoreboard bench for ch4_noise with an independent LFSR/timing model.
`default_nettype none

module tb_ch4_noise;

  logic        clk = 1'b0;
  logic        apu_reset = 1'b1;
  logic        ce_1m = 1'b0;
  logic        env_tick = 1'b0;
  logic [7:0]  ff21_q = 8'h00;
  logic [7:0]  ff22_q = 8'h00;
  logic        ch4_restart = 1'b0;
  logic        ch4_len_expire = 1'b0;
  logic        ch4_active;
  logic [3:0]  ch4_out;
  logic [14:0] lfsr_q;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [14:0] lfsr;
    logic [3:0]  out;
  } exp_t;
  exp_t sb[$];

  logic [14:0] m_lfsr;
  logic [3:0]  m_vol;
  logic        m_active;
  int          m_n;
  int          m_d;

  ch4_noise dut (
    .clk(clk), .apu_reset(apu_reset), .ce_1m(ce_1m), .env_tick(env_tick),
    .ff21_q(ff21_q), .ff22_q(ff22_q), .ch4_restart(ch4_restart),
    .ch4_len_expire(ch4_len_expire), .ch4_active(ch4_active),
    .ch4_out(ch4_out), .lfsr_q(lfsr_q)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] lfsr_next(input logic [14:0] v, input logic w);
    logic x;
    logic [14:0] n;
    x = v[0] ^ v[1];
    n = v >> 1;
    n[14] = x;
    if (w) n[6] = x;
    return n;
  endfunction

  function automatic logic [3:0] model_out();
    return (m_active && !m_lfsr[0]) ? m_vol : 4'd0;
  endfunction

  task automatic model_restart();
    m_lfsr   = 15'h7FFF;
    m_n      = 0;
    m_d      = (ff22_q[2:0] == 3'd0) ? 1 : 2 * int'(ff22_q[2:0]);
    m_active = (ff21_q[7:3] != 5'd0);
    m_vol    = ff21_q[7:4];
  endtask

  task automatic do_restart(input logic with_len);
    exp_t e;
    model_restart();
    e.lfsr = m_lfsr;
    e.out  = model_out();
    sb.push_back(e);
    ch4_restart = 1'b1;
    ch4_len_expire = with_len;
    @(posedge clk); #1;
    ch4_restart = 1'b0;
    ch4_len_expire = 1'b0;
    e = sb.pop_front();
    total++;
    if (ch4_active !== m_active || lfsr_q !== e.lfsr || ch4_out !== e.out) begin
      bad++;
      $display("FAIL restart: active=%b lfsr=%h out=%h expected active=%b lfsr=%h out=%h",
               ch4_active, lfsr_q, ch4_out, m_active, e.lfsr, e.out);
    end
  endtask

  task automatic ce_step(input bit chk);
    exp_t e;
    int p;
    int s;
    m_n++;
    if ((m_n % m_d) == 0) begin
      p = m_n / m_d;
      s = int'(ff22_q[7:4]);
      if (s < 14 && m_active && (p % (1 << (s + 1))) == (1 << s))
        m_lfsr = lfsr_next(m_lfsr, ff22_q[3]);
    end
    e.lfsr = m_lfsr;
    e.out  = model_out();
    sb.push_back(e);
    ce_1m = 1'b1;
    @(posedge clk); #1;
    ce_1m = 1'b0;
    e = sb.pop_front();
    if (chk) begin
      total++;
      if (lfsr_q !== e.lfsr || ch4_out !== e.out) begin
        bad++;
        $display("FAIL sb_ce n=%0d: lfsr=%h out=%h expected lfsr=%h out=%h",
                 m_n, lfsr_q, ch4_out, e.lfsr, e.out);
      end
    end
  endtask

  task automatic env_step(input logic [3:0] expv);
    exp_t e;
    e.lfsr = m_lfsr;
    e.out  = expv;
    sb.push_back(e);
    env_tick = 1'b1;
    @(posedge clk); #1;
    env_tick = 1'b0;
    e = sb.pop_front();
    total++;
    if (ch4_out !== e.out || lfsr_q !== e.lfsr) begin
      bad++;
      $display("FAIL env_tick: out=%h lfsr=%h expected out=%h lfsr=%h", ch4_out, lfsr_q, e.out, e.lfsr);
    end
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (ch4_active !== 1'b0 || ch4_out !== 4'd0 || lfsr_q !== 15'd0) begin
      bad++;
      $display("FAIL reset_state: active=%b out=%h lfsr=%h expected 0 0 0", ch4_active, ch4_out, lfsr_q);
    end
    apu_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lfsr15();
    ff21_q = 8'hF0;
    ff22_q = 8'h00;
    do_restart(1'b0);
    ce_step(1); ce_step(1);
    total++;
    if (lfsr_q !== 15'h3FFF) begin
      bad++;
      $display("FAIL lfsr15_first: lfsr=%h expected 3fff", lfsr_q);
    end
    for (int i = 0; i < 26; i++) ce_step(1);
    total++;
    if (ch4_out !== 4'h0) begin
      bad++;
      $display("FAIL lfsr15_shift14: out=%h expected 0", ch4_out);
    end
    ce_step(1); ce_step(1);
    total++;
    if (ch4_out !== 4'hF) begin
      bad++;
      $display("FAIL lfsr15_shift15: out=%h expected f", ch4_out);
    end
    for (int i = 0; i < 600; i++) ce_step(1);
  endtask

  task automatic test_lfsr7();
    logic [3:0] outs [0:254];
    int mism;
    ff21_q = 8'hF0;
    ff22_q = 8'h08;
    do_restart(1'b0);
    ce_step(1); ce_step(1);
    total++;
    if (lfsr_q !== 15'h3FBF) begin
      bad++;
      $display("FAIL lfsr7_first: lfsr=%h expected 3fbf", lfsr_q);
    end
    outs[1] = ch4_out;
    for (int k = 2; k <= 254; k++) begin
      ce_step(1); ce_step(1);
      outs[k] = ch4_out;
    end
    total++;
    if (outs[6] !== 4'h0 || outs[7] !== 4'hF) begin
      bad++;
      $display("FAIL lfsr7_onset: out6=%h out7=%h expected 0 f", outs[6], outs[7]);
    end
    mism = 0;
    for (int k = 1; k <= 127; k++) if (outs[k] !== outs[k + 127]) mism++;
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL lfsr7_period: mismatches=%0d expected 0", mism);
    end
  endtask

  task automatic test_period();
    int chg [0:2];
    int k;
    logic [14:0] prev;
    ff21_q = 8'hF0;
    ff22_q = 8'h23;
    do_restart(1'b0);
    prev = lfsr_q;
    k = 0;
    for (int i = 1; i <= 400 && k < 3; i++) begin
      ce_step(1);
      if (lfsr_q !== prev) begin
        chg[k] = i;
        k++;
        prev = lfsr_q;
      end
    end
    total++;
    if (k != 3) begin
      bad++;
      $display("FAIL period_timeout: shifts=%0d expected 3", k);
    end else if (chg[0] != 24 || chg[1] - chg[0] != 48 || chg[2] - chg[1] != 48) begin
      bad++;
      $display("FAIL period_interval: first=%0d gaps=%0d,%0d expected 24 48,48",
               chg[0], chg[1] - chg[0], chg[2] - chg[1]);
    end
  endtask

  task automatic test_freeze();
    ff21_q = 8'hF0;
    ff22_q = 8'hE0;
    do_restart(1'b0);
    for (int i = 0; i < 20000; i++) ce_step(i == 19999);
    total++;
    if (lfsr_q !== 15'h7FFF) begin
      bad++;
      $display("FAIL freeze_s14: lfsr=%h expected 7fff", lfsr_q);
    end
  endtask

  task automatic prime_b0_zero(input logic [7:0] nr42);
    ff21_q = nr42;
    ff22_q = 8'h00;
    do_restart(1'b0);
    for (int i = 0; i < 30; i++) ce_step(1);
    ff22_q = 8'hE0;
  endtask

  task automatic test_envelope();
`ifdef CH4_NOISE_ENV_EN
    logic [3:0] up_seq [0:9];
    up_seq = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd15, 4'd15, 4'd15};
    prime_b0_zero(8'h89);
    for (int i = 0; i < 10; i++) env_step(up_seq[i]);
    prime_b0_zero(8'h12);
    env_step(4'd1);
    env_step(4'd0);
    env_step(4'd0);
    env_step(4'd0);
`else
    prime_b0_zero(8'h89);
    for (int i = 0; i < 10; i++) env_step(4'd8);
`endif
  endtask

  task automatic test_events();
    ff21_q = 8'hF0;
    ff22_q = 8'hE0;
    do_restart(1'b1);
    ch4_len_expire = 1'b1;
    @(posedge clk); #1;
    ch4_len_expire = 1'b0;
    total++;
    if (ch4_active !== 1'b0 || ch4_out !== 4'd0) begin
      bad++;
      $display("FAIL len_expire: active=%b out=%h expected 0 0", ch4_active, ch4_out);
    end
    do_restart(1'b0);
    ff21_q = 8'h00;
    total++;
    if (ch4_active !== 1'b1) begin
      bad++;
      $display("FAIL dac_off_hold: active=%b expected 1", ch4_active);
    end
    @(posedge clk); #1;
    total++;
    if (ch4_active !== 1'b0 || ch4_out !== 4'd0) begin
      bad++;
      $display("FAIL dac_off: active=%b out=%h expected 0 0", ch4_active, ch4_out);
    end
    do_restart(1'b0);
    total++;
    if (ch4_active !== 1'b0 || ch4_out !== 4'd0) begin
      bad++;
      $display("FAIL restart_dac_off: active=%b out=%h expected 0 0", ch4_active, ch4_out);
    end
  endtask

  task automatic test_back_to_back_reset();
    prime_b0_zero(8'hF0);
    total++;
    if (ch4_active !== 1'b1 || ch4_out !== 4'hF) begin
      bad++;
      $display("FAIL pre_reset: active=%b out=%h expected 1 f", ch4_active, ch4_out);
    end
    @(posedge clk); #2;
    apu_reset = 1'b1;
    #1;
    total++;
    if (ch4_active !== 1'b0 || ch4_out !== 4'd0 || lfsr_q !== 15'd0) begin
      bad++;
      $display("FAIL async_reset: active=%b out=%h lfsr=%h expected 0 0 0", ch4_active, ch4_out, lfsr_q);
    end
    @(posedge clk); #1;
    apu_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lfsr15();
    test_lfsr7();
    test_period();
    test_freeze();
    test_envelope();
    test_events();
    test_back_to_back_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
